// File: rtl/fc_pkg.sv
// Shared constants for the fully connected layer row scheduler: data width,
// FSM encoding and the row index width helper.
package fc_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic int row_w(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/fc_tag_pipe.sv
// Per-lane {valid,row} delay line matching the dot-product lane latency (DP_LAT cycles).
// No backpressure: shifts every cycle; o_pend flags tags that still have cycles left to travel.
module fc_tag_pipe #(
    parameter int ROW_W  = 2,
    parameter int DP_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    input  logic [ROW_W-1:0] i_row,
    output logic             o_vld,
    output logic [ROW_W-1:0] o_row,
    output logic             o_pend
);

    // Every stage except the output one: those tags are captured in a later cycle.
    localparam logic [DP_LAT-1:0] PEND_MASK = {DP_LAT{1'b1}} >> 1;

    logic [DP_LAT-1:0] r_vld;
    logic [ROW_W-1:0]  r_row [DP_LAT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            for (int s = 0; s < DP_LAT; s++) begin
                r_row[s] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_row[0] <= i_row;
            for (int s = 1; s < DP_LAT; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_row[s] <= r_row[s-1];
            end
        end
    end

    assign o_vld  = r_vld[DP_LAT-1];
    assign o_row  = r_row[DP_LAT-1];
    assign o_pend = |(r_vld & PEND_MASK);

endmodule

// File: rtl/fc_row_scheduler.sv
// Hands M matrix rows to NUM_DP dot-product lanes, NUM_DP per cycle; done B+DP_LAT+1 cycles after start.
// No backpressure: lanes are always ready and results are captured DP_LAT cycles after issue.
module fc_row_scheduler
    import fc_pkg::*;
#(
    parameter int M      = 4,
    parameter int N      = 2,
    parameter int NUM_DP = 2,
    parameter int DP_LAT = 1,
    parameter int ROW_W  = fc_pkg::row_w(M)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [NUM_DP-1:0]         o_issue_valid,
    output logic [0:NUM_DP*ROW_W-1]   o_issue_row,
    input  logic [0:NUM_DP*DATA_W-1]  i_dp_result,
    output logic [0:M*DATA_W-1]       o_out_vector
);

    if (NUM_DP < 1 || NUM_DP > M || DP_LAT < 1 || N < 1) begin : g_bad_cfg
        $error("fc_row_scheduler: illegal parameter set");
    end

    // One spare bit so next_row can run past M on the last batch without wrapping.
    localparam int                CNT_W  = ROW_W + 1;
    localparam logic [CNT_W-1:0]  M_C    = CNT_W'(M);
    localparam logic [CNT_W-1:0]  STEP_C = CNT_W'(NUM_DP);

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_next_row;
    logic [0:M*DATA_W-1]      r_out;

    logic [NUM_DP-1:0]        w_issue_vld;
    logic [0:NUM_DP*ROW_W-1]  w_issue_row;
    logic [CNT_W-1:0]         w_row;
    logic [NUM_DP-1:0]        w_tag_vld;
    logic [NUM_DP-1:0]        w_tag_pend;
    logic [ROW_W-1:0]         w_tag_row [NUM_DP];

    always_comb begin
        w_issue_vld = '0;
        w_issue_row = '0;
        w_row       = '0;
        for (int k = 0; k < NUM_DP; k++) begin
            w_row = r_next_row + CNT_W'(k);
            if (r_state == S_ISSUE && w_row < M_C) begin
                w_issue_vld[k]                  = 1'b1;
                w_issue_row[k*ROW_W +: ROW_W]   = w_row[ROW_W-1:0];
            end
        end
    end

    for (genvar k = 0; k < NUM_DP; k++) begin : g_lane
        fc_tag_pipe #(
            .ROW_W  (ROW_W),
            .DP_LAT (DP_LAT)
        ) u_tag (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_vld  (w_issue_vld[k]),
            .i_row  (w_issue_row[k*ROW_W +: ROW_W]),
            .o_vld  (w_tag_vld[k]),
            .o_row  (w_tag_row[k]),
            .o_pend (w_tag_pend[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_next_row <= '0;
            r_out      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_ISSUE;
                        r_next_row <= '0;
                    end
                end
                S_ISSUE: begin
                    r_next_row <= r_next_row + STEP_C;
                    if (r_next_row + STEP_C >= M_C) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Output-stage tags are captured this cycle; only earlier stages hold us here.
                    if (!(|w_tag_pend)) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            for (int r = 0; r < M; r++) begin
                for (int k = 0; k < NUM_DP; k++) begin
                    if (w_tag_vld[k] && w_tag_row[k] == ROW_W'(r)) begin
                        r_out[r*DATA_W +: DATA_W] <= i_dp_result[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_issue_valid = w_issue_vld;
    assign o_issue_row   = w_issue_row;
    assign o_out_vector  = r_out;

endmodule

// File: tb/tb_fc_row_scheduler.sv
// Randomized scoreboard bench for fc_row_scheduler across several lane/latency configurations.
module tb_fc_row_scheduler;

    localparam int NCFG = 5;

    function automatic int cfg_m(input int g);
        case (g) 0: return 4; 1: return 5; 2: return 4; 3: return 4; default: return 3; endcase
    endfunction
    function automatic int cfg_d(input int g);
        case (g) 0: return 2; 1: return 2; 2: return 1; 3: return 2; default: return 3; endcase
    endfunction
    function automatic int cfg_l(input int g);
        case (g) 0: return 1; 1: return 2; 2: return 3; 3: return 2; default: return 4; endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int n_fin    = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int CM = cfg_m(g);
        localparam int CD = cfg_d(g);
        localparam int CL = cfg_l(g);
        localparam int RW = fc_pkg::row_w(CM);
        localparam int B  = (CM + CD - 1) / CD;

        logic                 rst   = 1'b1;
        logic                 start = 1'b0;
        logic                 busy;
        logic                 done;
        logic [CD-1:0]        iv;
        logic [0:CD*RW-1]     ir;
        logic [0:CD*16-1]     dpr   = '0;
        logic [0:CM*16-1]     ov;

        fc_row_scheduler #(
            .M      (CM),
            .N      (2),
            .NUM_DP (CD),
            .DP_LAT (CL)
        ) u_dut (
            .i_clk         (clk),
            .i_rst         (rst),
            .i_start       (start),
            .o_busy        (busy),
            .o_done        (done),
            .o_issue_valid (iv),
            .o_issue_row   (ir),
            .i_dp_result   (dpr),
            .o_out_vector  (ov)
        );

        logic [15:0]       data [CM];
        logic [0:CM*16-1]  cur_vec = '0;
        int                iq_cyc[$];
        int                iq_vld[$];
        logic [0:CD*RW-1]  iq_row[$];
        int                dq_cyc[$];
        logic [0:CM*16-1]  dq_vec[$];
        int                busy_lo = 1;
        int                busy_hi = 0;
        bit                mon_en  = 1'b0;
        bit                env_v [64][CD];
        int                env_r [64][CD];

        // Monitor: compares what the DUT presents against the scoreboard queues.
        always @(negedge clk) begin
            int               ec;
            int               ev;
            logic [0:CD*RW-1] er;
            logic [0:CM*16-1] evec;
            if (mon_en) begin
                chk($sformatf("g%0d busy@%0d", g, cyc), busy, (cyc >= busy_lo && cyc <= busy_hi));
                if (iv != '0) begin
                    if (iq_cyc.size() == 0) begin
                        chk($sformatf("g%0d unexpected_issue@%0d", g, cyc), iv, 0);
                    end else begin
                        ec = iq_cyc.pop_front();
                        ev = iq_vld.pop_front();
                        er = iq_row.pop_front();
                        chk($sformatf("g%0d issue_cycle", g), cyc, ec);
                        chk($sformatf("g%0d issue_valid@%0d", g, cyc), iv, ev);
                        chk($sformatf("g%0d issue_row@%0d", g, cyc), ir, er);
                    end
                end else begin
                    chk($sformatf("g%0d idle_row@%0d", g, cyc), ir, 0);
                end
                if (done) begin
                    if (dq_cyc.size() == 0) begin
                        chk($sformatf("g%0d unexpected_done@%0d", g, cyc), done, 0);
                    end else begin
                        ec   = dq_cyc.pop_front();
                        evec = dq_vec.pop_front();
                        chk($sformatf("g%0d done_cycle", g), cyc, ec);
                        chk($sformatf("g%0d out_vector@%0d", g, cyc), ov, evec);
                    end
                end
            end
            for (int k = 0; k < CD; k++) begin
                if (iv[k]) begin
                    env_v[(cyc + CL) % 64][k] = 1'b1;
                    env_r[(cyc + CL) % 64][k] = int'(ir[k*RW +: RW]);
                end
            end
        end

        // Lane model: returns data[row] exactly CL cycles after issue, junk otherwise.
        always @(posedge clk) begin
            #1;
            for (int k = 0; k < CD; k++) begin
                if (env_v[cyc % 64][k]) begin
                    dpr[k*16 +: 16] = data[env_r[cyc % 64][k]];
                    env_v[cyc % 64][k] = 1'b0;
                end else begin
                    dpr[k*16 +: 16] = 16'($urandom);
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        // Rows go out in order, CD per cycle from the cycle after start; all slots filled at done.
        task automatic launch(output int s, output logic [0:CM*16-1] vec);
            int               r;
            int               mask;
            logic [0:CD*RW-1] rows;
            s = cyc;
            chk($sformatf("g%0d retain@%0d", g, s), ov, cur_vec);
            for (int i = 0; i < CM; i++) data[i] = 16'($urandom);
            for (int b = 0; b < B; b++) begin
                mask = 0;
                rows = '0;
                for (int k = 0; k < CD; k++) begin
                    r = b * CD + k;
                    if (r < CM) begin
                        mask |= (1 << k);
                        rows[k*RW +: RW] = RW'(r);
                    end
                end
                iq_cyc.push_back(s + 1 + b);
                iq_vld.push_back(mask);
                iq_row.push_back(rows);
            end
            for (int i = 0; i < CM; i++) vec[i*16 +: 16] = data[i];
            dq_cyc.push_back(s + B + CL + 1);
            dq_vec.push_back(vec);
            busy_lo = s + 1;
            busy_hi = s + B + CL + 1;
            start   = 1'b1;
        endtask

        task automatic run_pass(input bit noisy);
            int               s;
            int               d;
            logic [0:CM*16-1] vec;
            launch(s, vec);
            d = s + B + CL + 1;
            do begin
                step();
                start = noisy && (cyc == s + 2 || cyc == d || $urandom_range(0, 3) == 0);
            end while (cyc < d);
            step();
            start   = 1'b0;
            cur_vec = vec;
        endtask

        task automatic run_reset_pass();
            int               s;
            logic [0:CM*16-1] vec;
            launch(s, vec);
            step();
            start = 1'b0;
            step();
            rst = 1'b1;
            while (iq_cyc.size() > 0 && iq_cyc[$] > s + 2) begin
                void'(iq_cyc.pop_back());
                void'(iq_vld.pop_back());
                void'(iq_row.pop_back());
            end
            while (dq_cyc.size() > 0 && dq_cyc[$] > s + 2) begin
                void'(dq_cyc.pop_back());
                void'(dq_vec.pop_back());
            end
            busy_hi = s + 2;
            step();
            rst = 1'b0;
            chk($sformatf("g%0d rst_busy", g), busy, 0);
            chk($sformatf("g%0d rst_done", g), done, 0);
            chk($sformatf("g%0d rst_issue", g), iv, 0);
            chk($sformatf("g%0d rst_out", g), ov, 0);
            cur_vec = '0;
            repeat (CL + 2) step();
            chk($sformatf("g%0d rst_dropped", g), ov, 0);
        endtask

        initial begin
            rst   = 1'b1;
            start = 1'b0;
            repeat (3) step();
            chk($sformatf("g%0d reset_busy", g), busy, 0);
            chk($sformatf("g%0d reset_done", g), done, 0);
            chk($sformatf("g%0d reset_issue_valid", g), iv, 0);
            chk($sformatf("g%0d reset_issue_row", g), ir, 0);
            chk($sformatf("g%0d reset_out", g), ov, 0);
            rst    = 1'b0;
            mon_en = 1'b1;
            step();
            run_pass(1'b1);
            run_pass(1'b0);
            run_pass(1'b0);
            run_reset_pass();
            run_pass(1'b0);
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 2)) step();
                run_pass(1'($urandom_range(0, 1)));
            end
            repeat (CL + 4) step();
            chk($sformatf("g%0d issue_queue_left", g), iq_cyc.size(), 0);
            chk($sformatf("g%0d done_queue_left", g), dq_cyc.size(), 0);
            n_fin++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && n_fin < NCFG; t++) @(posedge clk);
        if (n_fin < NCFG) begin
            checks++;
            failures++;
            $display("FAIL timeout finished=%0d required=%0d", n_fin, NCFG);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
